gmii_tx_monitor: RTL and testbench

Synthesizable per-port monitor placed directly downstream of a bridge GMII transmit port (gmii_tx_dv_N / gmii_txd_N). It delineates each frame, strips preamble/SFD, captures DA/SA, counts length, checks FCS, and pushes one status record per frame into a small report FIFO. The FIFO drains over an srdy/drdy interface to a scoreboard or statistics block. One instance is used per bridge port.

---
 rtl/gmii_tx_monitor.sv | 176 +++++++++++++++++
 tb/tb_gmii_tx_monitor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_monitor.sv
// Per-port GMII transmit monitor: frame delineation, DA/SA capture, length/FCS checks, report FIFO.
// Define GMII_MON_CRC_EN to build the FCS checker; otherwise rpt_status[2] is tied to 0.
module gmii_tx_monitor #(
   parameter int MIN_LEN    = 64,
   parameter int MAX_LEN    = 1518,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        gmii_tx_dv,
   input  logic [7:0]  gmii_txd,
   output logic        rpt_srdy,
   input  logic        rpt_drdy,
   output logic [47:0] rpt_da,
   output logic [47:0] rpt_sa,
   output logic [15:0] rpt_len,
   output logic [3:0]  rpt_status,
   output logic [15:0] frame_cnt,
   output logic [15:0] ovf_cnt
);
   // state    | meaning
   // IDLE     | between frames, waiting for dv
   // PREAMBLE | receiving 0x55 bytes, waiting for SFD
   // DATA     | after SFD, counting/capturing/CRC-ing bytes
   // DROP     | bad preamble byte seen, discarding until dv falls
   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

   localparam int          AW     = $clog2(FIFO_DEPTH);
   localparam int          RW     = 116;
   localparam logic [15:0] MIN_L  = 16'(MIN_LEN);
   localparam logic [15:0] MAX_L  = 16'(MAX_LEN);

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [47:0] da_q, da_d, sa_q, sa_d;
   logic        push, pop, full, empty, push_ok;
   logic        pre_err, crc_err, giant, runt;
   logic [RW-1:0] rec_d;
   logic [RW-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic [15:0] frame_cnt_q, ovf_cnt_q;

`ifdef GMII_MON_CRC_EN
   logic [31:0] crc_q, crc_d;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction
`endif

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      da_d    = da_q;
      sa_d    = sa_q;
      push    = 1'b0;
`ifdef GMII_MON_CRC_EN
      crc_d   = crc_q;
`endif
      case (state_q)
         IDLE: begin
            if (gmii_tx_dv) begin
               if (gmii_txd == 8'h55)      state_d = PREAMBLE;
               else if (gmii_txd == 8'hD5) state_d = DATA;
               else                        state_d = DROP;
            end
         end
         PREAMBLE: begin
            if (!gmii_tx_dv) begin
               push    = 1'b1;
               state_d = IDLE;
            end else if (gmii_txd == 8'hD5) state_d = DATA;
            else if (gmii_txd != 8'h55)     state_d = DROP;
         end
         DATA: begin
            if (!gmii_tx_dv) begin
               push    = 1'b1;
               state_d = IDLE;
            end else begin
               if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
               for (int i = 0; i < 6; i++) begin
                  if (len_q == 16'(i))     da_d[8*(5-i) +: 8] = gmii_txd;
                  if (len_q == 16'(i + 6)) sa_d[8*(5-i) +: 8] = gmii_txd;
               end
`ifdef GMII_MON_CRC_EN
               crc_d = crc_byte(crc_q, gmii_txd);
`endif
            end
         end
         DROP: begin
            if (!gmii_tx_dv) begin
               push    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Accumulators stay cleared outside DATA so a frame can start one cycle after a push.
      if (state_q != DATA) begin
         len_d = '0;
         da_d  = '0;
         sa_d  = '0;
`ifdef GMII_MON_CRC_EN
         crc_d = 32'hFFFFFFFF;
`endif
      end
   end

   assign pre_err = (state_q != DATA);
`ifdef GMII_MON_CRC_EN
   assign crc_err = !pre_err && (crc_q != 32'hDEBB20E3);
`else
   assign crc_err = 1'b0;
`endif
   assign giant   = !pre_err && (len_q > MAX_L);
   assign runt    = !pre_err && (len_q < MIN_L);
   assign rec_d   = {da_q, sa_q, len_q, pre_err, crc_err, giant, runt};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         da_q    <= '0;
         sa_q    <= '0;
`ifdef GMII_MON_CRC_EN
         crc_q   <= 32'hFFFFFFFF;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         da_q    <= da_d;
         sa_q    <= sa_d;
`ifdef GMII_MON_CRC_EN
         crc_q   <= crc_d;
`endif
      end
   end

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop     = !empty && rpt_drdy;
   // A simultaneous pop frees the head slot, so a full FIFO can still accept.
   assign push_ok = push && (!full || pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         frame_cnt_q <= '0;
         ovf_cnt_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= rec_d;
            wr_ptr_q                <= wr_ptr_q + 1'b1;
            frame_cnt_q             <= frame_cnt_q + 16'd1;
         end else if (push && ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   assign rpt_srdy   = !empty;
   assign rpt_da     = mem_q[rd_ptr_q[AW-1:0]][115:68];
   assign rpt_sa     = mem_q[rd_ptr_q[AW-1:0]][67:20];
   assign rpt_len    = mem_q[rd_ptr_q[AW-1:0]][19:4];
   assign rpt_status = mem_q[rd_ptr_q[AW-1:0]][3:0];
   assign frame_cnt  = frame_cnt_q;
   assign ovf_cnt    = ovf_cnt_q;

endmodule

// File: tb/tb_gmii_tx_monitor.sv
// Directed bench for gmii_tx_monitor: table of frames plus overflow and mid-frame reset sequences.
module tb_gmii_tx_monitor;
   logic        clk = 1'b0;
   logic        reset;
   logic        gmii_tx_dv;
   logic [7:0]  gmii_txd;
   logic        rpt_srdy;
   logic        rpt_drdy;
   logic [47:0] rpt_da, rpt_sa;
   logic [15:0] rpt_len;
   logic [3:0]  rpt_status;
   logic [15:0] frame_cnt, ovf_cnt;

   int checks = 0;
   int errors = 0;

`ifdef GMII_MON_CRC_EN
   localparam logic CRC_ON = 1'b1;
`else
   localparam logic CRC_ON = 1'b0;
`endif

   gmii_tx_monitor #(.MIN_LEN(64), .MAX_LEN(1518), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .gmii_tx_dv(gmii_tx_dv), .gmii_txd(gmii_txd),
      .rpt_srdy(rpt_srdy), .rpt_drdy(rpt_drdy), .rpt_da(rpt_da), .rpt_sa(rpt_sa),
      .rpt_len(rpt_len), .rpt_status(rpt_status), .frame_cnt(frame_cnt), .ovf_cnt(ovf_cnt)
   );

   always #5 clk = ~clk;

   // mode 0: good preamble + frame, 1: bad preamble byte then junk, 2: dv drops in preamble
   typedef struct {
      int          mode;
      int          pre_n;
      int          nbytes;
      bit          flip;
      logic [47:0] da;
      logic [47:0] sa;
      logic [15:0] elen;
      logic [3:0]  est;
   } vec_t;

   vec_t tv[11];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // Called at posedge+1; returns at posedge+1 of the edge that sees dv=0 (report push edge).
   task automatic send_frame(input int mode, input int pre_n, input int nbytes, input bit flip,
                             input logic [47:0] da, input logic [47:0] sa);
      logic [7:0]  q[$];
      logic [7:0]  body[$];
      logic [31:0] crc;
      for (int i = 0; i < pre_n; i++) q.push_back(8'h55);
      if (mode == 0) begin
         q.push_back(8'hD5);
         for (int i = 0; i < 6; i++) body.push_back(da[47-8*i -: 8]);
         for (int i = 0; i < 6; i++) body.push_back(sa[47-8*i -: 8]);
         for (int i = 12; i < nbytes - 4; i++) body.push_back(8'((i * 7) + 3));
         crc = 32'hFFFFFFFF;
         foreach (body[i]) crc = crc_upd(crc, body[i]);
         crc = ~crc;
         body.push_back(crc[7:0]);
         body.push_back(crc[15:8]);
         body.push_back(crc[23:16]);
         body.push_back(flip ? ~crc[31:24] : crc[31:24]);
         foreach (body[i]) q.push_back(body[i]);
      end else if (mode == 1) begin
         q.push_back(8'h12);
         for (int i = 0; i < nbytes; i++) q.push_back(8'(8'hA0 + i));
      end
      foreach (q[i]) begin
         gmii_tx_dv = 1'b1;
         gmii_txd   = q[i];
         @(posedge clk); #1;
      end
      gmii_tx_dv = 1'b0;
      gmii_txd   = 8'h00;
      @(posedge clk); #1;
   endtask

   initial begin
      tv[0]  = '{0, 7,   64, 1'b0, 48'h000000000002, 48'h000000000001, 16'd64,   4'b0000};
      tv[1]  = '{0, 7,   64, 1'b1, 48'h000000000002, 48'h000000000001, 16'd64,   {1'b0, CRC_ON, 2'b00}};
      tv[2]  = '{0, 0,   64, 1'b0, 48'h0A1B2C3D4E5F, 48'h6071829304A5, 16'd64,   4'b0000};
      tv[3]  = '{0, 7,   20, 1'b0, 48'h112233445566, 48'h778899AABBCC, 16'd20,   4'b0001};
      tv[4]  = '{0, 7,   63, 1'b0, 48'h000000000002, 48'h000000000001, 16'd63,   4'b0001};
      tv[5]  = '{0, 3, 1518, 1'b0, 48'hFFFFFFFFFFFF, 48'h020000000001, 16'd1518, 4'b0000};
      tv[6]  = '{0, 7, 1519, 1'b0, 48'h000000000002, 48'h000000000001, 16'd1519, 4'b0010};
      tv[7]  = '{0, 7, 1600, 1'b1, 48'h000000000002, 48'h000000000001, 16'd1600, {1'b0, CRC_ON, 2'b10}};
      tv[8]  = '{1, 2,   30, 1'b0, 48'h0, 48'h0, 16'd0, 4'b1000};
      tv[9]  = '{2, 3,    0, 1'b0, 48'h0, 48'h0, 16'd0, 4'b1000};
      tv[10] = '{1, 0,    5, 1'b0, 48'h0, 48'h0, 16'd0, 4'b1000};

      reset      = 1'b1;
      gmii_tx_dv = 1'b0;
      gmii_txd   = 8'h00;
      rpt_drdy   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_srdy",   64'(rpt_srdy),   64'd0);
      chk("rst_da",     64'(rpt_da),     64'd0);
      chk("rst_sa",     64'(rpt_sa),     64'd0);
      chk("rst_len",    64'(rpt_len),    64'd0);
      chk("rst_status", 64'(rpt_status), 64'd0);
      chk("rst_fcnt",   64'(frame_cnt),  64'd0);
      chk("rst_ovf",    64'(ovf_cnt),    64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      foreach (tv[k]) begin
         send_frame(tv[k].mode, tv[k].pre_n, tv[k].nbytes, tv[k].flip, tv[k].da, tv[k].sa);
         chk($sformatf("v%0d_srdy", k),   64'(rpt_srdy),   64'd1);
         chk($sformatf("v%0d_len", k),    64'(rpt_len),    64'(tv[k].elen));
         chk($sformatf("v%0d_status", k), 64'(rpt_status), 64'(tv[k].est));
         chk($sformatf("v%0d_da", k),     64'(rpt_da),     64'(tv[k].da));
         chk($sformatf("v%0d_sa", k),     64'(rpt_sa),     64'(tv[k].sa));
         chk($sformatf("v%0d_fcnt", k),   64'(frame_cnt),  64'(k + 1));
         @(posedge clk); #1;
         chk($sformatf("v%0d_srdy_pulse", k), 64'(rpt_srdy), 64'd0);
      end

      // Overflow: six back-to-back frames with one-cycle IPG into a 4-deep FIFO.
      reset = 1'b1;
      #2;
      reset    = 1'b0;
      rpt_drdy = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++)
         send_frame(0, 7, 64 + i, 1'b0, 48'h000000000002, 48'h000000000001);
      chk("ovf_fcnt", 64'(frame_cnt), 64'd4);
      chk("ovf_ovf",  64'(ovf_cnt),   64'd2);
      repeat (3) @(posedge clk);
      #1;
      chk("ovf_hold_len", 64'(rpt_len), 64'd64);
      rpt_drdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("pop%0d_srdy", i), 64'(rpt_srdy), 64'd1);
         chk($sformatf("pop%0d_len", i),  64'(rpt_len),  64'(64 + i));
         @(posedge clk); #1;
      end
      chk("drain_srdy", 64'(rpt_srdy), 64'd0);

      // Mid-frame reset with a report still held.
      rpt_drdy = 1'b0;
      send_frame(0, 7, 70, 1'b0, 48'h000000000002, 48'h000000000001);
      chk("pre_rst_fcnt", 64'(frame_cnt), 64'd5);
      gmii_tx_dv = 1'b1;
      gmii_txd   = 8'h55;
      @(posedge clk); #1;
      gmii_txd = 8'hD5;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         gmii_txd = 8'(i + 1);
         @(posedge clk); #1;
      end
      reset = 1'b1;
      #1;
      chk("mid_rst_srdy", 64'(rpt_srdy),  64'd0);
      chk("mid_rst_len",  64'(rpt_len),   64'd0);
      chk("mid_rst_da",   64'(rpt_da),    64'd0);
      chk("mid_rst_fcnt", 64'(frame_cnt), 64'd0);
      chk("mid_rst_ovf",  64'(ovf_cnt),   64'd0);
      gmii_tx_dv = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      reset    = 1'b0;
      rpt_drdy = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_idle", 64'(rpt_srdy), 64'd0);
      send_frame(0, 7, 64, 1'b0, 48'h000000000002, 48'h000000000001);
      chk("post_rst_srdy",   64'(rpt_srdy),   64'd1);
      chk("post_rst_len",    64'(rpt_len),    64'd64);
      chk("post_rst_status", 64'(rpt_status), 64'd0);
      chk("post_rst_fcnt",   64'(frame_cnt),  64'd1);
      @(posedge clk); #1;
      chk("post_rst_single", 64'(rpt_srdy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
